multi_interval_timer: RTL and testbench

- N-channel interval timer sharing one clock-rate prescaler; generalises the single-channel 0..7 s interval counter.
- Adds parametrised count width, channel count, tick rate, per-channel start/stop/pause and one-shot or auto-reload mode.
- Sits between game FSM and mole/LED logic; each channel times one mole window or round timer independently.

---
 rtl/multi_interval_timer.sv | 136 +++++++++++++
 tb/tb_multi_interval_timer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_interval_timer.sv
// rtl/multi_interval_timer.sv - N-channel interval timer with a shared tick prescaler

`ifndef CLK_FREQ
`define CLK_FREQ 50_000_000
`endif

module multi_interval_timer #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 3,
    parameter int CLK_FREQ = `CLK_FREQ,
    parameter int TICK_HZ  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH-1:0]         stop,
    input  logic [N_CH-1:0]         hold,
    input  logic [N_CH-1:0]         reload,
    input  logic [N_CH-1:0]         dir,
    input  logic [N_CH*CNT_W-1:0]   interval,
    output logic [N_CH*CNT_W-1:0]   count,
    output logic [N_CH-1:0]         timeout,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         done
);

    // DIV must divide evenly and be at least 2, so the prescaler is always >= 1 bit
    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    // Free-running prescaler shared by every channel; start/stop never touch it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] lim_q;
        logic             dir_q;
        logic             rel_q;
        logic             to_q;
        logic             busy_q;
        logic             done_q;
        logic [CNT_W-1:0] in_iv;
        logic             terminal;

        assign in_iv    = interval[i*CNT_W +: CNT_W];
        assign terminal = dir_q ? (cnt_q == lim_q) : (cnt_q == '0);

        assign count[i*CNT_W +: CNT_W] = cnt_q;
        assign timeout[i]              = to_q;
        assign busy[i]                 = busy_q;
        assign done[i]                 = done_q;

        // Channel FSM: start > stop > hold > tick; timeout is a registered one-cycle pulse
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= IDLE;
                cnt_q  <= '0;
                lim_q  <= '0;
                dir_q  <= 1'b0;
                rel_q  <= 1'b0;
                to_q   <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                to_q <= 1'b0;
                if (start[i]) begin
                    lim_q  <= in_iv;
                    dir_q  <= dir[i];
                    rel_q  <= reload[i];
                    cnt_q  <= dir[i] ? '0 : in_iv;
                    state  <= hold[i] ? PAUSE : RUN;
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                end else if (stop[i] && (state != IDLE)) begin
                    // Count is left frozen so software can read where it stopped
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end else begin
                    case (state)
                        RUN: begin
                            if (hold[i]) begin
                                state <= PAUSE;
                            end else if (tick) begin
                                if (terminal) begin
                                    to_q <= 1'b1;
                                    if (rel_q) begin
                                        cnt_q <= dir_q ? '0 : lim_q;
                                    end else begin
                                        state  <= DONE;
                                        busy_q <= 1'b0;
                                        done_q <= 1'b1;
                                    end
                                end else if (dir_q) begin
                                    cnt_q <= cnt_q + CNT_W'(1);
                                end else begin
                                    cnt_q <= cnt_q - CNT_W'(1);
                                end
                            end
                        end
                        PAUSE: begin
                            if (!hold[i]) begin
                                state <= RUN;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_interval_timer.sv
// tb/tb_multi_interval_timer.sv - scoreboard bench for multi_interval_timer

module tb_multi_interval_timer;

    localparam int N_CH  = 4;
    localparam int CNT_W = 3;
    localparam int DIV   = 10;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_CH-1:0]       start = '0;
    logic [N_CH-1:0]       stop = '0;
    logic [N_CH-1:0]       hold = '0;
    logic [N_CH-1:0]       reload = '0;
    logic [N_CH-1:0]       dir = '0;
    logic [N_CH*CNT_W-1:0] interval = '0;
    logic [N_CH*CNT_W-1:0] count;
    logic [N_CH-1:0]       timeout;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       done;

    multi_interval_timer #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .CLK_FREQ (DIV),
        .TICK_HZ  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .hold     (hold),
        .reload   (reload),
        .dir      (dir),
        .interval (interval),
        .count    (count),
        .timeout  (timeout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int at;
    } ev_t;

    ev_t q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  edge_n;

    // Posedges since reset release; ticks land on edges that are multiples of DIV
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_n);
        end
    endtask

    function automatic int cnt(input int ch);
        return int'(count[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic set_ch(input int ch, input logic d, input logic r, input int iv);
        dir[ch]                      = d;
        reload[ch]                   = r;
        interval[ch*CNT_W +: CNT_W]  = CNT_W'(iv);
    endtask

    task automatic expect_to(input int ch, input int at);
        ev_t e;
        e.ch = ch;
        e.at = at;
        q.push_back(e);
    endtask

    task automatic goto(input int n);
        int g = 0;
        while (edge_n < n && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (edge_n != n) check_eq("goto", edge_n, n);
    endtask

    // Scoreboard: every cycle the timeout vector must equal exactly the events due now
    always @(negedge clk) begin
        if (!rst && edge_n != 0) begin
            logic [N_CH-1:0] exp_mask;
            exp_mask = '0;
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (q[k].at == edge_n) begin
                    exp_mask[q[k].ch] = 1'b1;
                    q.delete(k);
                end
            end
            check_eq("timeout", int'(timeout), int'(exp_mask));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_count", int'(count), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_timeout", int'(timeout), 0);
        rst = 1'b0;

        // All four channels start together on edge 5
        goto(4);
        set_ch(0, 1'b1, 1'b0, 3);
        set_ch(1, 1'b0, 1'b1, 5);
        set_ch(2, 1'b1, 1'b0, 2);
        set_ch(3, 1'b0, 1'b0, 0);
        start = 4'hF;
        expect_to(3, 10);
        expect_to(0, 40);
        expect_to(1, 60);
        expect_to(2, 60);
        expect_to(1, 120);
        goto(5);
        start = '0;
        check_eq("c0_start", cnt(0), 0);
        check_eq("c1_start", cnt(1), 5);
        check_eq("c2_start", cnt(2), 0);
        check_eq("c3_start", cnt(3), 0);
        check_eq("busy_start", int'(busy), 15);

        goto(12);
        hold = 4'b0100;
        goto(15);
        check_eq("c0_t1", cnt(0), 1);
        check_eq("c1_t1", cnt(1), 4);
        check_eq("c2_t1", cnt(2), 1);
        check_eq("done3_iv0", int'(done[3]), 1);
        check_eq("busy3_iv0", int'(busy[3]), 0);
        goto(25);
        check_eq("c0_t2", cnt(0), 2);
        check_eq("c2_hold", cnt(2), 1);
        check_eq("busy2_hold", int'(busy[2]), 1);
        goto(33);
        interval[1*CNT_W +: CNT_W] = 3'd7;
        goto(35);
        check_eq("c0_t3", cnt(0), 3);
        check_eq("c2_hold2", cnt(2), 1);
        goto(42);
        hold = '0;
        goto(45);
        check_eq("c0_final", cnt(0), 3);
        check_eq("done0", int'(done[0]), 1);
        check_eq("busy0_done", int'(busy[0]), 0);
        check_eq("c1_t4", cnt(1), 1);
        check_eq("c2_resume", cnt(2), 1);
        goto(55);
        check_eq("c1_zero", cnt(1), 0);
        check_eq("c2_t", cnt(2), 2);
        goto(65);
        check_eq("c1_reload", cnt(1), 5);
        check_eq("busy1_reload", int'(busy[1]), 1);
        check_eq("done2", int'(done[2]), 1);

        // Restart ch0 as a longer up-count, stop ch1
        goto(124);
        set_ch(0, 1'b1, 1'b0, 5);
        start = 4'b0001;
        stop  = 4'b0010;
        goto(125);
        start = '0;
        stop  = '0;
        check_eq("c1_stopped", cnt(1), 5);
        check_eq("busy1_stop", int'(busy[1]), 0);
        check_eq("c0_restart", cnt(0), 0);
        check_eq("done0_clr", int'(done[0]), 0);
        goto(144);
        stop = 4'b0001;
        goto(145);
        stop = '0;
        check_eq("c0_stop", cnt(0), 2);
        check_eq("busy0_stop", int'(busy[0]), 0);
        check_eq("done0_stop", int'(done[0]), 0);

        // ch3 restarted exactly on its terminal tick
        goto(164);
        set_ch(3, 1'b1, 1'b1, 1);
        start = 4'b1000;
        goto(165);
        start = '0;
        check_eq("c0_frozen", cnt(0), 2);
        check_eq("c3_start", cnt(3), 0);
        check_eq("done3_clr", int'(done[3]), 0);
        goto(175);
        check_eq("c3_t1", cnt(3), 1);
        goto(179);
        start = 4'b1000;
        expect_to(3, 200);
        goto(180);
        start = '0;
        check_eq("c3_collide", cnt(3), 0);
        goto(195);
        check_eq("c3_t1b", cnt(3), 1);
        goto(204);
        stop = 4'b1000;
        goto(205);
        stop = '0;
        check_eq("c3_reload0", cnt(3), 0);
        check_eq("busy3_stop", int'(busy[3]), 0);

        // All channels running, then an asynchronous reset between edges
        goto(214);
        for (int c = 0; c < N_CH; c++) set_ch(c, 1'b1, 1'b1, 7);
        start = 4'hF;
        goto(215);
        start = '0;
        goto(233);
        check_eq("busy_all", int'(busy), 15);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_count", int'(count), 0);
        check_eq("arst_busy", int'(busy), 0);
        check_eq("arst_done", int'(done), 0);
        check_eq("arst_timeout", int'(timeout), 0);
        check_eq("queue_pre_rst", q.size(), 0);
        @(negedge clk);
        rst = 1'b0;

        // Prescaler restarts at 0: first tick lands on edge DIV
        goto(1);
        set_ch(0, 1'b1, 1'b0, 0);
        start = 4'b0001;
        expect_to(0, 10);
        goto(2);
        start = '0;
        check_eq("post_c0", cnt(0), 0);
        check_eq("post_busy0", int'(busy[0]), 1);
        goto(12);
        check_eq("post_done0", int'(done[0]), 1);
        check_eq("post_busy0b", int'(busy[0]), 0);
        goto(15);
        check_eq("queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
